// File: rtl/delay_meter_pkg.sv
// Shared definitions for the loop-latency meter and the delay-line
// calibration software: FSM state encoding and default sizing.
package delay_meter_pkg;

    localparam int unsigned WIDTH_DEF         = 16;
    localparam int unsigned DELAY_WIDTH_DEF   = 8;
    localparam int unsigned SETTLE_CYCLES_DEF = 16;
    localparam logic signed [WIDTH_DEF-1:0] STIM_AMPL_DEF = 16'sh4000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STEP   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/delay_meter.sv
// Loop-latency meter: holds stim_o at 0 to let the loop settle, drives a step,
// then counts edges until the returned data_i reaches the latched threshold.
// The reported delta equals the number of pipeline registers in the loop.
//
// Handshake: start_i is accepted only in IDLE (busy_o low) on a rising edge;
// there is no back-pressure. Every accepted start yields exactly one
// single-cycle valid_o pulse (with timeout_o alongside when no crossing was
// seen); delta_o holds its value until the next result.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned DELAY_WIDTH   = DELAY_WIDTH_DEF,
    parameter logic signed [WIDTH-1:0] STIM_AMPL = STIM_AMPL_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic signed [WIDTH-1:0] threshold_i,
    input  logic signed [WIDTH-1:0] data_i,
    output logic signed [WIDTH-1:0] stim_o,
    output logic [DELAY_WIDTH-1:0]  delta_o,
    output logic                    valid_o,
    output logic                    timeout_o,
    output logic                    busy_o,
    output state_t                  state_o
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
    // All-ones is reserved for the timeout result, so the counter gives up
    // one step before reaching it and never wraps.
    localparam logic [DELAY_WIDTH-1:0] CNT_LAST = {{(DELAY_WIDTH-1){1'b1}}, 1'b0};

    state_t                  state;
    logic [SETTLE_W-1:0]     settle_cnt;
    logic [DELAY_WIDTH-1:0]  cnt;
    logic signed [WIDTH-1:0] thr;

    assign state_o = state;

    // Measurement FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            cnt        <= '0;
            thr        <= '0;
            stim_o     <= '0;
            delta_o    <= '0;
            valid_o    <= 1'b0;
            timeout_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stim_o <= '0;
                    if (start_i) begin
                        thr        <= threshold_i;
                        busy_o     <= 1'b1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        stim_o <= STIM_AMPL;
                        cnt    <= '0;
                        state  <= ST_STEP;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_STEP: begin
                    if (data_i >= thr) begin
                        delta_o <= cnt;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        stim_o  <= '0;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        delta_o   <= '1;
                        valid_o   <= 1'b1;
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        stim_o    <= '0;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    stim_o <= '0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter: a variable-length register loop closes
// stim_o back onto data_i, and each measurement is compared against the
// loop length chosen by the test.
module tb_delay_meter;
    import delay_meter_pkg::*;

    localparam int SC = 16;
    localparam logic signed [15:0] AMPL = 16'sh4000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic signed [15:0] threshold = '0;
    logic signed [15:0] data;
    logic signed [15:0] stim;
    logic [7:0]         delta;
    logic               valid, timeout, busy;
    state_t             state;

    delay_meter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .threshold_i(threshold),
        .data_i     (data),
        .stim_o     (stim),
        .delta_o    (delta),
        .valid_o    (valid),
        .timeout_o  (timeout),
        .busy_o     (busy),
        .state_o    (state)
    );

    // ---------------- loop model ----------------
    int loop_len = 0;
    logic loop_open = 1'b0;
    logic signed [15:0] dl [0:63];

    initial for (int i = 0; i < 64; i++) dl[i] = '0;

    always @(posedge clk) begin
        dl[0] <= stim;
        for (int i = 1; i < 64; i++) dl[i] <= dl[i-1];
    end

    always_comb begin
        data = '0;
        if (!loop_open) data = (loop_len == 0) ? stim : dl[loop_len-1];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    int         m_lat, m_busy, m_valids;
    logic [7:0] m_delta;
    logic       m_to;
    logic signed [15:0] m_stim_at_valid, m_stim_before;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One start pulse; optional re-pulse of start at cycle extra_at and a
    // threshold change after acceptance. Watches for valid_o, then checks
    // that no further pulse appears.
    task automatic measure(input logic signed [15:0] thr, input int extra_at,
                           input logic scramble);
        int cyc;
        logic signed [15:0] prev;
        cyc = 0; m_busy = 0; m_valids = 0; m_lat = -1; prev = '0;
        threshold = thr;
        start = 1'b1;
        while (m_lat < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (extra_at != 0 && cyc == extra_at) ? 1'b1 : 1'b0;
            if (scramble) threshold = 16'sh7fff;
            if (busy) m_busy++;
            if (valid) begin
                m_valids++;
                m_lat = cyc;
                m_delta = delta;
                m_to = timeout;
                m_stim_at_valid = stim;
                m_stim_before = prev;
            end
            prev = stim;
        end
        start = 1'b0;
        if (m_lat < 0) check("valid_wait_timeout", 32'd0, 32'd1);
        repeat (20) begin
            @(negedge clk);
            if (valid) m_valids++;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] held_deltas[$];

    initial begin
        // reset state
        #12;
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_delta", 32'(delta), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        @(negedge clk); rst = 1'b0;
        idle(3);

        // direct wire
        loop_len = 0;
        measure(16'sh2000, 0, 1'b0);
        check("direct_delta", 32'(m_delta), 32'd0);
        check("direct_timeout", 32'(m_to), 32'd0);
        check("direct_busy_cycles", 32'(m_busy), 32'(SC + 2));
        check("direct_latency", 32'(m_lat), 32'(SC + 3));
        check("direct_valid_count", 32'(m_valids), 32'd1);
        check("direct_stim_done", 32'(m_stim_at_valid), 32'd0);
        idle(60);

        // 5 and 37 register loops; threshold changed after acceptance
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd37);
        foreach (exp_q[i]) begin
            loop_len = int'(exp_q[i]);
            measure(16'sh2000, 0, 1'b1);
            check("loop_delta", 32'(m_delta), exp_q[i]);
            check("loop_timeout", 32'(m_to), 32'd0);
            check("loop_latency", 32'(m_lat), 32'(SC + 3) + exp_q[i]);
            check("loop_valid_count", 32'(m_valids), 32'd1);
            threshold = '0;
            idle(80);
        end

        // open loop -> timeout after 255 step cycles
        loop_open = 1'b1;
        measure(16'sh0100, 0, 1'b0);
        check("open_delta", 32'(m_delta), 32'hff);
        check("open_timeout", 32'(m_to), 32'd1);
        check("open_latency", 32'(m_lat), 32'(SC + 257));
        check("open_stim_before", 32'(m_stim_before), 32'(AMPL));
        check("open_stim_done", 32'(m_stim_at_valid), 32'd0);
        check("open_valid_count", 32'(m_valids), 32'd1);
        loop_open = 1'b0;
        idle(60);

        // threshold equal to amplitude is a crossing; one above is not
        loop_len = 3;
        measure(16'sh4000, 0, 1'b0);
        check("eq_thr_delta", 32'(m_delta), 32'd3);
        check("eq_thr_timeout", 32'(m_to), 32'd0);
        idle(60);
        measure(16'sh4001, 0, 1'b0);
        check("above_thr_delta", 32'(m_delta), 32'hff);
        check("above_thr_timeout", 32'(m_to), 32'd1);
        idle(60);

        // negative threshold: first step compare already crosses
        loop_len = 5;
        measure(-16'sh0100, 0, 1'b0);
        check("neg_thr_delta", 32'(m_delta), 32'd0);
        idle(60);

        // start re-pulsed mid-STEP is ignored
        measure(16'sh2000, SC + 4, 1'b0);
        check("restart_delta", 32'(m_delta), 32'd5);
        check("restart_valid_count", 32'(m_valids), 32'd1);
        idle(60);

        // start held high -> back-to-back results
        threshold = 16'sh2000;
        start = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (held_deltas.size() < 2 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (valid) begin
                    held_deltas.push_back(32'(delta));
                    if (held_deltas.size() == 2) start = 1'b0;
                end
            end
            start = 1'b0;
            check("held_result_count", 32'(held_deltas.size()), 32'd2);
            foreach (held_deltas[i]) check("held_delta", held_deltas[i], 32'd5);
        end
        idle(80);

        // async reset mid-STEP
        begin
            int seen_valid;
            seen_valid = 0;
            threshold = 16'sh2000;
            loop_len = 37;
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            idle(SC + 10);
            check("pre_rst_busy", 32'(busy), 32'd1);
            check("pre_rst_stim", 32'(stim), 32'(AMPL));
            #2 rst = 1'b1;
            #1;
            check("mid_rst_stim", 32'(stim), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
            check("mid_rst_delta", 32'(delta), 32'd0);
            check("mid_rst_state", 32'(state), 32'(ST_IDLE));
            repeat (3) begin @(negedge clk); if (valid) seen_valid++; end
            rst = 1'b0;
            repeat (80) begin @(negedge clk); if (valid) seen_valid++; end
            check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
        end
        loop_len = 5;
        measure(16'sh2000, 0, 1'b0);
        check("post_rst_delta", 32'(m_delta), 32'd5);
        check("post_rst_timeout", 32'(m_to), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
